// File: rtl/uart_rx_controller_if.sv
// uart_rx_controller_if
// Character-side handshake between the UART receive sequencer and the
// character consumer.
//   data_out      : last received character (LSB was first on the line)
//   data_valid    : character available, held until read_ack
//   read_ack      : one-cycle consumer acknowledge
//   framing_error : last frame ended with a low stop bit
//   overrun       : a character completed while the previous one was unread
//   busy          : receiver is inside a frame
// master = receiver side, slave = consumer side.
interface uart_rx_controller_if #(
    parameter int DATA_BITS = 8
) ();
    logic [DATA_BITS-1:0] data_out;
    logic                 data_valid;
    logic                 read_ack;
    logic                 framing_error;
    logic                 overrun;
    logic                 busy;

    modport master (
        output data_out,
        output data_valid,
        output framing_error,
        output overrun,
        output busy,
        input  read_ack
    );

    modport slave (
        input  data_out,
        input  data_valid,
        input  framing_error,
        input  overrun,
        input  busy,
        output read_ack
    );
endinterface

// File: rtl/uart_rx_controller.sv
// uart_rx_controller
// Framed receive sequencer for an oversampled UART line. Detects and
// validates the start bit, samples each data bit near mid-bit, checks the
// stop bit and hands the character over through a valid/ack handshake.
// Ports:
//   clk_i        : oversample clock, one line sample per rising edge
//   rst_ni       : asynchronous active-low reset
//   serial_in_i  : raw serial line, idle high, asynchronous to clk_i
//   rx_if        : character handshake (master side), see uart_rx_controller_if
module uart_rx_controller #(
    parameter int SAMPLES_PER_BIT = 16,
    parameter int DATA_BITS       = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 serial_in_i,
    uart_rx_controller_if.master rx_if
);
    localparam int CW = $clog2(SAMPLES_PER_BIT);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [CW-1:0] CNT_HALF = CW'(SAMPLES_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLES_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t               state_q;
    logic                 sync1_q;
    logic                 rx_s_q;
    logic [CW-1:0]        cnt_q;
    logic [BW-1:0]        bitn_q;
    logic [DATA_BITS-1:0] sh_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 ferr_q;
    logic                 ovr_q;
    logic                 busy_q;

    // New bit enters at the MSB; after DATA_BITS shifts the first (LSB-first)
    // bit has walked down to bit 0.
    logic [DATA_BITS:0]   sh_ext;
    assign sh_ext = {rx_s_q, sh_q};

    assign rx_if.data_out      = data_q;
    assign rx_if.data_valid    = valid_q;
    assign rx_if.framing_error = ferr_q;
    assign rx_if.overrun       = ovr_q;
    assign rx_if.busy          = busy_q;

    // Two-flop synchronizer; resets to the idle (high) line level so that
    // reset release never looks like a start bit.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
        end else begin
            sync1_q <= serial_in_i;
            rx_s_q  <= sync1_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bitn_q  <= '0;
            sh_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            // Consumer acknowledge; a successful stop sample below in the same
            // cycle overrides data_valid back to 1 while overrun stays clear.
            if (rx_if.read_ack && valid_q) begin
                valid_q <= 1'b0;
                ovr_q   <= 1'b0;
            end

            unique case (state_q)
                S_IDLE: begin
                    cnt_q  <= '0;
                    bitn_q <= '0;
                    if (!rx_s_q) begin
                        state_q <= S_START;
                        busy_q  <= 1'b1;
                    end
                end

                S_START: begin
                    if (cnt_q == CNT_HALF) begin
                        cnt_q <= '0;
                        if (rx_s_q) begin
                            // Line went back high before mid start bit: glitch.
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= S_DATA;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                S_DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q  <= '0;
                        sh_q   <= sh_ext[DATA_BITS:1];
                        bitn_q <= bitn_q + BW'(1);
                        if (bitn_q == BIT_LAST) begin
                            state_q <= S_STOP;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                S_STOP: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        if (rx_s_q) begin
                            data_q  <= sh_q;
                            valid_q <= 1'b1;
                            ferr_q  <= 1'b0;
                            if (valid_q && !rx_if.read_ack) begin
                                ovr_q <= 1'b1;
                            end
                        end else begin
                            // Bad stop bit: the assembled character is dropped.
                            ferr_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end
endmodule
